// File: rtl/scl_ctrl_if.sv
// rtl/scl_ctrl_if.sv - scaler control video-timing, config and filter-enable signal bundle
interface scl_ctrl_if;
    logic scl_i_vsync;
    logic scl_i_hsync;
    logic scl_i_data_en;
    logic scl_cfg_mode;
    logic scl_cfg_rsz;
    logic en_ff0;
    logic en_ff1;
    logic en_ff2;
    logic en_ff3;
    logic scl_o_data_en;
    logic scl_o_vsync;
    logic scl_o_hsync;

    modport master (
        output scl_i_vsync, scl_i_hsync, scl_i_data_en, scl_cfg_mode, scl_cfg_rsz,
        input  en_ff0, en_ff1, en_ff2, en_ff3, scl_o_data_en, scl_o_vsync, scl_o_hsync
    );

    modport slave (
        input  scl_i_vsync, scl_i_hsync, scl_i_data_en, scl_cfg_mode, scl_cfg_rsz,
        output en_ff0, en_ff1, en_ff2, en_ff3, scl_o_data_en, scl_o_vsync, scl_o_hsync
    );
endinterface

// File: rtl/scl_ctrl.sv
// rtl/scl_ctrl.sv - scaler line/frame sequencer driving filter tap enables and output valid
// Optional FLUSH state (3 trailing tap-shift cycles per line) built when SCL_CTRL_FLUSH_EN is defined.
module scl_ctrl (
    input  logic       clk_scl,
    input  logic       rst_n_scl,
    scl_ctrl_if.slave  bus
);

`ifdef SCL_CTRL_FLUSH_EN
    typedef enum logic [1:0] {IDLE, WAIT_LINE, ACTIVE, FLUSH} state_t;
    logic [1:0] flush_cnt;
`else
    typedef enum logic [1:0] {IDLE, WAIT_LINE, ACTIVE} state_t;
`endif

    state_t     state;
    logic [3:0] vs_dly;
    logic [3:0] hs_dly;
    logic [1:0] phase;
    logic       shd_mode;
    logic       shd_rsz;
    logic [2:0] keep_dly;
    logic       en0, en1, en2, en3;
    logic       out_de;

    logic       vs_rise;
    logic       hs_rise;
    logic       accept;
    logic       keep;
    logic [1:0] cur_phase;
    logic [1:0] nxt_phase;

    always_comb begin
        vs_rise   = vs_dly[0] & ~vs_dly[1];
        hs_rise   = hs_dly[0] & ~hs_dly[1];
        // A frame start wins over a coincident pixel, which is dropped.
        accept    = bus.scl_i_data_en && (state != IDLE) && !vs_rise;
        cur_phase = hs_rise ? 2'd0 : phase;
        if (!shd_mode)
            keep = 1'b1;
        else if (!shd_rsz)
            keep = (cur_phase[0] == 1'b0);
        else
            keep = (cur_phase != 2'd3);
        nxt_phase = cur_phase + 2'd1;
        if (!shd_rsz)
            nxt_phase[1] = 1'b0;
    end

    always_ff @(posedge clk_scl or negedge rst_n_scl) begin
        if (!rst_n_scl) begin
            state    <= IDLE;
            vs_dly   <= 4'd0;
            hs_dly   <= 4'd0;
            phase    <= 2'd0;
            shd_mode <= 1'b0;
            shd_rsz  <= 1'b0;
            keep_dly <= 3'd0;
            en0      <= 1'b0;
            en1      <= 1'b0;
            en2      <= 1'b0;
            en3      <= 1'b0;
            out_de   <= 1'b0;
`ifdef SCL_CTRL_FLUSH_EN
            flush_cnt <= 2'd0;
`endif
        end else begin
            vs_dly   <= {vs_dly[2:0], bus.scl_i_vsync};
            hs_dly   <= {hs_dly[2:0], bus.scl_i_hsync};
            en0      <= accept;
            en1      <= en0;
            en2      <= en1;
            en3      <= en2;
            keep_dly <= {keep_dly[1:0], accept & keep};
            out_de   <= keep_dly[2];

            if (accept)
                phase <= nxt_phase;
            else if (hs_rise)
                phase <= 2'd0;

            if (vs_rise) begin
                state    <= WAIT_LINE;
                phase    <= 2'd0;
                shd_mode <= bus.scl_cfg_mode;
                shd_rsz  <= bus.scl_cfg_rsz;
            end else begin
                case (state)
                    IDLE: state <= IDLE;
                    WAIT_LINE: if (bus.scl_i_data_en) state <= ACTIVE;
                    ACTIVE: begin
                        if (!bus.scl_i_data_en) begin
`ifdef SCL_CTRL_FLUSH_EN
                            state     <= FLUSH;
                            flush_cnt <= 2'd0;
`else
                            state     <= WAIT_LINE;
`endif
                        end
                    end
`ifdef SCL_CTRL_FLUSH_EN
                    FLUSH: begin
                        // Incoming data takes priority over draining the taps.
                        if (bus.scl_i_data_en) begin
                            state <= ACTIVE;
                        end else begin
                            en0       <= 1'b1;
                            flush_cnt <= flush_cnt + 2'd1;
                            if (flush_cnt == 2'd2)
                                state <= WAIT_LINE;
                        end
                    end
`endif
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.en_ff0        = en0;
    assign bus.en_ff1        = en1;
    assign bus.en_ff2        = en2;
    assign bus.en_ff3        = en3;
    assign bus.scl_o_data_en = out_de;
    assign bus.scl_o_vsync   = vs_dly[3];
    assign bus.scl_o_hsync   = hs_dly[3];

endmodule

// File: tb/tb_scl_ctrl.sv
// tb/tb_scl_ctrl.sv - randomized scoreboard bench for scl_ctrl against a frame/line-level model
`timescale 1ns/1ps
module tb_scl_ctrl;
    localparam int MAXC = 8192;
`ifdef SCL_CTRL_FLUSH_EN
    localparam int FLUSH_N = 3;
`else
    localparam int FLUSH_N = 0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    scl_ctrl_if bus();

    scl_ctrl dut (
        .clk_scl   (clk),
        .rst_n_scl (rst_n),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    bit exp_en0 [MAXC];
    bit h_vs    [MAXC];
    bit h_hs    [MAXC];
    bit h_rst   [MAXC];
    int exp_q   [$];

    // Frame/line-level reference state
    bit frame_open = 0;
    bit shd_mode = 0;
    bit shd_rsz = 0;
    int k = 0;
    bit in_line = 0;
    int flush_left = 0;
    bit prev_vs = 0;
    bit prev_hs = 0;
    int vs_rise_at = -1;
    int hs_rise_at = -1;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit win_ok(int q, int n);
        if (q - n < 0) return 1'b0;
        for (int i = q - n; i <= q; i++)
            if (!h_rst[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic cycle(input bit vs, input bit hs, input bit de);
        int p;
        p = cyc;
        bus.scl_i_vsync   = vs;
        bus.scl_i_hsync   = hs;
        bus.scl_i_data_en = de;
        if (p < MAXC - 8) begin
            h_vs[p]  = vs;
            h_hs[p]  = hs;
            h_rst[p] = rst_n;
            if (!rst_n) begin
                frame_open = 0; in_line = 0; flush_left = 0; k = 0;
                vs_rise_at = -1; hs_rise_at = -1;
                while (exp_q.size() > 0 && exp_q[exp_q.size()-1] >= p) void'(exp_q.pop_back());
            end else begin
                if (p == vs_rise_at) begin
                    frame_open = 1; shd_mode = bus.scl_cfg_mode; shd_rsz = bus.scl_cfg_rsz;
                    k = 0; in_line = 0; flush_left = 0;
                end else if (frame_open) begin
                    if (p == hs_rise_at) k = 0;
                    if (de) begin
                        exp_en0[p+1] = 1'b1;
                        if (!shd_mode || (!shd_rsz ? (k % 2 == 0) : (k % 4 != 3)))
                            exp_q.push_back(p + 4);
                        k++; in_line = 1; flush_left = 0;
                    end else if (flush_left > 0) begin
                        exp_en0[p+1] = 1'b1;
                        flush_left--;
                    end else if (in_line) begin
                        in_line = 0;
                        flush_left = FLUSH_N;
                    end
                end
                if (vs && !prev_vs) vs_rise_at = p + 1;
                if (hs && !prev_hs) hs_rise_at = p + 1;
            end
        end
        prev_vs = rst_n ? vs : 1'b0;
        prev_hs = rst_n ? hs : 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic line(input int npix, input bit bubbles);
        cycle(0, 1, 0);
        repeat (3) cycle(0, 0, 0);
        for (int i = 0; i < npix; i++) begin
            if (bubbles && $urandom_range(0, 5) == 0)
                repeat ($urandom_range(1, 4)) cycle(0, 0, 0);
            cycle(0, 0, 1);
        end
        repeat (6) cycle(0, 0, 0);
    endtask

    task automatic frame(input bit mode, input bit rsz, input int nlines, input int npix,
                         input bit bubbles, input bit toggle);
        bus.scl_cfg_mode = mode;
        bus.scl_cfg_rsz  = rsz;
        cycle(1, 0, 0);
        cycle(1, 0, 0);
        repeat (3) cycle(0, 0, 0);
        if (toggle) begin
            bus.scl_cfg_mode = ~mode;
            bus.scl_cfg_rsz  = ~rsz;
        end
        for (int l = 0; l < nlines; l++) line(npix, bubbles);
    endtask

    always @(negedge clk) begin
        int q;
        int act;
        q = cyc;
        if (q < MAXC) begin
            if (rst_n === 1'b0) begin
                act = {bus.en_ff0, bus.en_ff1, bus.en_ff2, bus.en_ff3,
                       bus.scl_o_data_en, bus.scl_o_vsync, bus.scl_o_hsync};
                chk("reset_outputs", act, 0);
            end else begin
                while (exp_q.size() > 0 && exp_q[0] < q) begin
                    chk("out_missed", q, exp_q[0]);
                    void'(exp_q.pop_front());
                end
                if (bus.scl_o_data_en) begin
                    if (exp_q.size() == 0) chk("out_unexpected", q, -1);
                    else begin
                        chk("out_timing", q, exp_q[0]);
                        void'(exp_q.pop_front());
                    end
                end
                chk("en_ff0", bus.en_ff0, int'(win_ok(q, 0) && exp_en0[q]));
                chk("en_ff1", bus.en_ff1, int'(win_ok(q, 1) && exp_en0[q-1]));
                chk("en_ff2", bus.en_ff2, int'(win_ok(q, 2) && exp_en0[q-2]));
                chk("en_ff3", bus.en_ff3, int'(win_ok(q, 3) && exp_en0[q-3]));
                chk("o_vsync", bus.scl_o_vsync, int'(win_ok(q, 4) && h_vs[q-4]));
                chk("o_hsync", bus.scl_o_hsync, int'(win_ok(q, 4) && h_hs[q-4]));
            end
        end
    end

    initial begin
        bus.scl_i_vsync = 0; bus.scl_i_hsync = 0; bus.scl_i_data_en = 0;
        bus.scl_cfg_mode = 0; bus.scl_cfg_rsz = 0;
        rst_n = 0;
        #1;
        repeat (4) cycle(0, 0, 0);
        rst_n = 1;
        repeat (6) cycle(0, 0, 1);
        repeat (3) cycle(0, 0, 0);

        frame(0, 0, 1, 8, 0, 0);
        frame(1, 0, 1, 8, 0, 0);
        frame(1, 1, 1, 8, 0, 0);
        frame(1, 0, 2, 8, 0, 1);

        // Line split by a two-cycle gap: data returns on the second trailing cycle.
        frame(1, 1, 0, 0, 0, 0);
        cycle(0, 1, 0);
        repeat (3) cycle(0, 0, 0);
        repeat (4) cycle(0, 0, 1);
        repeat (2) cycle(0, 0, 0);
        repeat (4) cycle(0, 0, 1);
        repeat (6) cycle(0, 0, 0);

        // Pixel coincident with frame start is dropped.
        cycle(1, 0, 0);
        cycle(0, 0, 1);
        repeat (3) cycle(0, 0, 0);
        line(6, 0);

        repeat (25) frame($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(1, 3),
                          $urandom_range(1, 12), 1'b1, $urandom_range(0, 1));

        // Reset mid-line, then data ignored until the next frame start.
        bus.scl_cfg_mode = 0;
        cycle(1, 0, 0);
        repeat (3) cycle(0, 0, 0);
        cycle(0, 1, 0);
        repeat (3) cycle(0, 0, 0);
        repeat (5) cycle(0, 0, 1);
        rst_n = 0;
        repeat (2) cycle(0, 0, 1);
        rst_n = 1;
        repeat (4) cycle(0, 0, 1);
        repeat (4) cycle(0, 0, 0);
        frame(0, 0, 1, 5, 0, 0);

        repeat (10) cycle(0, 0, 0);
        chk("out_drain", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
